// File: rtl/step_dir_decoder.sv
// Step/direction input decoder.
// Synchronizes an asynchronous step/direction pair, tracks a signed 32-bit
// position and a saturating accepted-step count, measures the step period,
// reports motion / idle status, and flags pulse-width and direction timing errors.
//
// Ports:
//   i_Clk            clock
//   i_rst_n          synchronous active-low reset
//   i_step           asynchronous step pulse
//   i_direction      asynchronous direction (1 = +, 0 = -)
//   i_clear          zeroes position, step count and error flags
//   o_position       signed position (two's complement, wrapping)
//   o_step_count     accepted-step count (saturating)
//   o_step_valid     one-cycle pulse per accepted step
//   o_last_period    cycles between the last two rising edges
//   o_moving         motion in progress
//   o_idle_pulse     one-cycle pulse when motion stops
//   o_err_short_high sticky: step high shorter than MIN_HIGH
//   o_err_short_low  sticky: step low shorter than MIN_LOW
//   o_err_dir_change sticky: direction changed while step high
module step_dir_decoder #(
  parameter int unsigned MIN_HIGH     = 2500,
  parameter int unsigned MIN_LOW      = 2500,
  parameter int unsigned IDLE_TIMEOUT = 20000
) (
  input  logic        i_Clk,
  input  logic        i_rst_n,
  input  logic        i_step,
  input  logic        i_direction,
  input  logic        i_clear,
  output logic [31:0] o_position,
  output logic [31:0] o_step_count,
  output logic        o_step_valid,
  output logic [19:0] o_last_period,
  output logic        o_moving,
  output logic        o_idle_pulse,
  output logic        o_err_short_high,
  output logic        o_err_short_low,
  output logic        o_err_dir_change
);

  localparam int unsigned POS_W  = 32;
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned IDLE_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [POS_W-1:0] STEP_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_nxt;

  logic [1:0]        step_sync;
  logic [1:0]        dir_sync;
  logic              step_s;
  logic              dir_s;
  logic              step_d;
  logic              dir_d;
  logic              rise;
  logic              fall;

  logic [CNT_W-1:0]  width_cnt;
  logic [CNT_W-1:0]  period_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic              rise_from_low;
  logic              timeout;
  logic              set_short_high;
  logic              set_short_low;
  logic              set_dir_change;

  logic              evt_step;
  logic              evt_dir;
  logic              evt_tmo;

  logic [POS_W-1:0]  pos_q;
  logic [POS_W-1:0]  cnt_q;
  logic [POS_W-1:0]  pos_nxt;
  logic [POS_W-1:0]  cnt_nxt;

  assign step_s = step_sync[1];
  assign dir_s  = dir_sync[1];
  assign rise   = step_s & ~step_d;
  assign fall   = ~step_s & step_d;

  // Two-flop synchronizers plus one-cycle history for edge detection
  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      step_sync <= '0;
      dir_sync  <= '0;
      step_d    <= 1'b0;
      dir_d     <= 1'b0;
    end else begin
      step_sync <= {step_sync[0], i_step};
      dir_sync  <= {dir_sync[0], i_direction};
      step_d    <= step_s;
      dir_d     <= dir_s;
    end
  end

  // Decoder state register
  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and per-cycle event decode
  always_comb begin
    state_nxt      = state_q;
    rise_from_low  = 1'b0;
    timeout        = 1'b0;
    set_short_low  = 1'b0;
    set_dir_change = 1'b0;
    set_short_high = fall && (32'(width_cnt) < MIN_HIGH);
    case (state_q)
      S_IDLE: begin
        if (rise) state_nxt = S_HIGH;
      end
      S_HIGH: begin
        set_dir_change = (dir_s != dir_d);
        if (fall) state_nxt = S_LOW;
      end
      S_LOW: begin
        if (rise) begin
          state_nxt     = S_HIGH;
          rise_from_low = 1'b1;
          set_short_low = (32'(width_cnt) < MIN_LOW);
        end else if (idle_cnt >= IDLE_TIMEOUT) begin
          state_nxt = S_IDLE;
          timeout   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Width / period / idle counters, period capture, error flags, event stage
  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      width_cnt        <= '0;
      period_cnt       <= '0;
      idle_cnt         <= '0;
      o_last_period    <= '0;
      o_err_short_high <= 1'b0;
      o_err_short_low  <= 1'b0;
      o_err_dir_change <= 1'b0;
      evt_step         <= 1'b0;
      evt_dir          <= 1'b0;
      evt_tmo          <= 1'b0;
    end else begin
      if (rise || fall)             width_cnt <= CNT_W'(1);
      else if (width_cnt != CNT_MAX) width_cnt <= width_cnt + CNT_W'(1);

      if (rise)                       period_cnt <= CNT_W'(1);
      else if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_W'(1);

      if (rise)                           idle_cnt <= IDLE_W'(1);
      else if (idle_cnt < IDLE_TIMEOUT)   idle_cnt <= idle_cnt + IDLE_W'(1);

      if (rise_from_low) o_last_period <= period_cnt;

      // Clear takes effect first so a same-cycle error still latches
      o_err_short_high <= (o_err_short_high & ~i_clear) | set_short_high;
      o_err_short_low  <= (o_err_short_low  & ~i_clear) | set_short_low;
      o_err_dir_change <= (o_err_dir_change & ~i_clear) | set_dir_change;

      // Direction is captured at the rising edge and travels with the step
      evt_step <= rise;
      evt_dir  <= dir_s;
      evt_tmo  <= timeout;
    end
  end

  // Clear applies before a coincident step
  always_comb begin
    pos_nxt = i_clear ? '0 : pos_q;
    cnt_nxt = i_clear ? '0 : cnt_q;
    if (evt_step) begin
      pos_nxt = evt_dir ? pos_nxt + POS_W'(1) : pos_nxt - POS_W'(1);
      if (cnt_nxt != STEP_MAX) cnt_nxt = cnt_nxt + POS_W'(1);
    end
  end

  // Output stage: position, count, step strobe, motion status
  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      pos_q        <= '0;
      cnt_q        <= '0;
      o_step_valid <= 1'b0;
      o_moving     <= 1'b0;
      o_idle_pulse <= 1'b0;
    end else begin
      pos_q        <= pos_nxt;
      cnt_q        <= cnt_nxt;
      o_step_valid <= evt_step;
      o_idle_pulse <= evt_tmo;
      if (evt_step)     o_moving <= 1'b1;
      else if (evt_tmo) o_moving <= 1'b0;
    end
  end

  assign o_position   = pos_q;
  assign o_step_count = cnt_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Self-checking bench for step_dir_decoder (scaled timing parameters).
module tb_step_dir_decoder;

  localparam int MIN_H = 25;
  localparam int MIN_L = 25;
  localparam int T     = 200;

  logic        i_Clk;
  logic        i_rst_n;
  logic        i_step;
  logic        i_direction;
  logic        i_clear;
  logic [31:0] o_position;
  logic [31:0] o_step_count;
  logic        o_step_valid;
  logic [19:0] o_last_period;
  logic        o_moving;
  logic        o_idle_pulse;
  logic        o_err_short_high;
  logic        o_err_short_low;
  logic        o_err_dir_change;

  step_dir_decoder #(
    .MIN_HIGH     (MIN_H),
    .MIN_LOW      (MIN_L),
    .IDLE_TIMEOUT (T)
  ) dut (
    .i_Clk            (i_Clk),
    .i_rst_n          (i_rst_n),
    .i_step           (i_step),
    .i_direction      (i_direction),
    .i_clear          (i_clear),
    .o_position       (o_position),
    .o_step_count     (o_step_count),
    .o_step_valid     (o_step_valid),
    .o_last_period    (o_last_period),
    .o_moving         (o_moving),
    .o_idle_pulse     (o_idle_pulse),
    .o_err_short_high (o_err_short_high),
    .o_err_short_low  (o_err_short_low),
    .o_err_dir_change (o_err_dir_change)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference state
  logic [31:0] m_pos;
  logic [31:0] m_cnt;
  logic [31:0] m_lp;
  bit          m_sh, m_sl, m_dir;
  int          m_nvalid = 0;
  int          m_nidle  = 0;
  bit          have_prev;
  int          prev_p, prev_l;

  // Output monitor
  int cyc       = 0;
  int mon_valid = 0;
  int mon_idle  = 0;
  int valid_cyc = 0;
  int idle_cyc  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge i_Clk);
      cyc++;
      if (o_step_valid === 1'b1) begin
        mon_valid++;
        valid_cyc = cyc;
      end
      if (o_idle_pulse === 1'b1) begin
        mon_idle++;
        idle_cyc = cyc;
        check("moving_low_at_idle_pulse", 32'(o_moving), 32'd0);
      end
    end
  end

  task automatic model_reset();
    m_pos = '0; m_cnt = '0; m_lp = '0;
    m_sh = 0; m_sl = 0; m_dir = 0;
    have_prev = 0; prev_p = 0; prev_l = 0;
  endtask

  task automatic model_clear();
    m_pos = '0; m_cnt = '0;
    m_sh = 0; m_sl = 0; m_dir = 0;
  endtask

  // One pulse of h cycles high then l cycles low; motion stops when a period exceeds T
  task automatic model_step(input int h, input int l, input bit d, input bit flip);
    if (have_prev && prev_p <= T) begin
      if (prev_l < MIN_L) m_sl = 1;
      m_lp = 32'(prev_p);
    end
    m_pos = d ? m_pos + 32'd1 : m_pos - 32'd1;
    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (h < MIN_H) m_sh = 1;
    if (flip) m_dir = 1;
    m_nvalid++;
    if (h + l > T) m_nidle++;
    have_prev = 1;
    prev_p = h + l;
    prev_l = l;
  endtask

  // Entered and left at a falling clock edge
  task automatic pulse(input int h, input int l, input bit d, input bit flip);
    model_step(h, l, d, flip);
    i_direction = d;
    i_step = 1'b1;
    for (int i = 1; i <= h; i++) begin
      @(negedge i_Clk);
      if (flip && i == h / 2) i_direction = ~i_direction;
    end
    i_step = 1'b0;
    repeat (l) @(negedge i_Clk);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    @(negedge i_Clk);
    i_clear = 1'b0;
    model_clear();
  endtask

  task automatic check_all(input string tag);
    check({tag, ":position"},    o_position,    m_pos);
    check({tag, ":step_count"},  o_step_count,  m_cnt);
    check({tag, ":last_period"}, 32'(o_last_period), m_lp);
    check({tag, ":err_short_high"}, 32'(o_err_short_high), 32'(m_sh));
    check({tag, ":err_short_low"},  32'(o_err_short_low),  32'(m_sl));
    check({tag, ":err_dir_change"}, 32'(o_err_dir_change), 32'(m_dir));
    check({tag, ":valid_pulses"}, 32'(mon_valid), 32'(m_nvalid));
    check({tag, ":idle_pulses"},  32'(mon_idle),  32'(m_nidle));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":position"},    o_position,   32'd0);
    check({tag, ":step_count"},  o_step_count, 32'd0);
    check({tag, ":last_period"}, 32'(o_last_period), 32'd0);
    check({tag, ":step_valid"},  32'(o_step_valid),   32'd0);
    check({tag, ":moving"},      32'(o_moving),       32'd0);
    check({tag, ":idle_pulse"},  32'(o_idle_pulse),   32'd0);
    check({tag, ":errors"}, 32'({o_err_short_high, o_err_short_low, o_err_dir_change}), 32'd0);
  endtask

  initial begin
    int h, l;
    bit d, f;
    i_rst_n = 1'b0; i_step = 1'b0; i_direction = 1'b0; i_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge i_Clk);
    check_zero("reset");
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_Clk);

    // Ten clean forward pulses, then let motion time out
    for (int i = 0; i < 9; i++) pulse(50, 50, 1, 0);
    check("s1:moving_mid", 32'(o_moving), 32'd1);
    pulse(50, 300, 1, 0);
    check_all("s1");
    check("s1:pos_const", o_position, 32'd10);
    check("s1:last_period_const", 32'(o_last_period), 32'd100);
    check("s1:idle_latency", 32'(idle_cyc - valid_cyc), 32'(T));
    check("s1:moving_end", 32'(o_moving), 32'd0);

    // Direction reversal during the low phase
    do_clear();
    for (int i = 0; i < 4; i++) pulse(50, 50, 1, 0);
    for (int i = 0; i < 6; i++) pulse(50, 50, 0, 0);
    pulse(50, 300, 0, 0);
    check_all("s2");
    check("s2:pos_const", o_position, 32'hFFFF_FFFD);
    check("s2:count_const", o_step_count, 32'd11);

    // Short high and short low, then clear
    do_clear();
    pulse(10, 10, 1, 0);
    pulse(50, 300, 1, 0);
    check_all("s3");
    check("s3:short_high_const", 32'(o_err_short_high), 32'd1);
    check("s3:short_low_const",  32'(o_err_short_low),  32'd1);
    do_clear();
    check_all("s3_clear");

    // Direction change while high keeps the step's original direction
    pulse(40, 300, 1, 1);
    check_all("s4");
    check("s4:dir_err_const", 32'(o_err_dir_change), 32'd1);

    // Idle timeout boundary: period == T keeps motion, T+1 stops it
    do_clear();
    pulse(50, T - 50, 1, 0);
    pulse(50, T + 1 - 50, 1, 0);
    pulse(50, 300, 1, 0);
    check_all("s5");
    check("s5:last_period_const", 32'(o_last_period), 32'(T));

    // Position wrap and count saturation from a preloaded state
    @(negedge i_Clk);
    force dut.pos_q = 32'h7FFF_FFFF;
    force dut.cnt_q = 32'hFFFF_FFFE;
    @(negedge i_Clk);
    release dut.pos_q;
    release dut.cnt_q;
    m_pos = 32'h7FFF_FFFF;
    m_cnt = 32'hFFFF_FFFE;
    pulse(50, 50, 1, 0);
    check("s6:pos_wrap_up", o_position, 32'h8000_0000);
    check("s6:count_full", o_step_count, 32'hFFFF_FFFF);
    pulse(50, 300, 0, 0);
    check("s6:pos_wrap_down", o_position, 32'h7FFF_FFFF);
    check("s6:count_sat", o_step_count, 32'hFFFF_FFFF);
    check_all("s6");

    // Clear coincident with an accepted reverse step, with latency check
    model_clear();
    model_step(50, 300, 0, 0);
    i_direction = 1'b0;
    i_step = 1'b1;
    repeat (3) @(negedge i_Clk);
    check("s7:valid_not_early", 32'(o_step_valid), 32'd0);
    i_clear = 1'b1;
    @(negedge i_Clk);
    i_clear = 1'b0;
    check("s7:valid_latency", 32'(o_step_valid), 32'd1);
    check("s7:pos", o_position, 32'hFFFF_FFFF);
    check("s7:count", o_step_count, 32'd1);
    repeat (46) @(negedge i_Clk);
    i_step = 1'b0;
    repeat (300) @(negedge i_Clk);
    check_all("s7");

    // Randomized pulse train
    for (int i = 0; i < 40; i++) begin
      h = int'($urandom_range(1, 60));
      l = ($urandom_range(0, 9) == 0) ? 250 : int'($urandom_range(1, 60));
      d = 1'($urandom_range(0, 1));
      f = (h >= 4) && ($urandom_range(0, 7) == 0);
      pulse(h, l, d, f);
    end
    pulse(30, 300, 1, 0);
    check_all("rand");

    // Reset during a high phase at position 5
    do_clear();
    for (int i = 0; i < 4; i++) pulse(50, 50, 1, 0);
    i_direction = 1'b1;
    i_step = 1'b1;
    repeat (10) @(negedge i_Clk);
    m_nvalid++;
    check("s8:pos_before_reset", o_position, 32'd5);
    check("s8:lp_before_reset", 32'(o_last_period), 32'd100);
    i_rst_n = 1'b0;
    @(negedge i_Clk);
    i_rst_n = 1'b1;
    check_zero("s8_reset");
    model_reset();
    pulse(50, 300, 1, 0);
    check_all("s8");
    check("s8:count_const", o_step_count, 32'd1);
    check("s8:lp_const", 32'(o_last_period), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
